// File: rtl/hsi_pkg.sv
// hsi_pkg: shared types for the HSI vector engine.
//   hsi_op_e    : operation codes accepted on op_code_i
//   ERR_*       : error codes pulsed on error_code_o
//   hsi_state_e : engine FSM states
package hsi_pkg;

    typedef enum logic [3:0] {
        OP_DOT    = 4'd1,
        OP_MUL    = 4'd2,
        OP_SQDIST = 4'd3
    } hsi_op_e;

    localparam logic [3:0] ERR_NONE       = 4'd0;
    localparam logic [3:0] ERR_BAD_OP     = 4'd1;
    localparam logic [3:0] ERR_ZERO_BANDS = 4'd2;
    localparam logic [3:0] ERR_TIMEOUT    = 4'd4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWrite,
        StDone
    } hsi_state_e;

endpackage

// File: rtl/hsi_mac_unit.sv
// hsi_mac_unit: combinational arithmetic for one band.
//   a_i, b_i : signed band samples
//   op_i     : operation; OP_SQDIST selects (a-b)^2, anything else a*b
//   term_o   : term widened to ACC_WIDTH (product sign-extended, square zero-extended)
module hsi_mac_unit
    import hsi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ACC_WIDTH     = 48,
    parameter int unsigned OP_CODE_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    a_i,
    input  logic [DATA_WIDTH-1:0]    b_i,
    input  logic [OP_CODE_WIDTH-1:0] op_i,
    output logic [ACC_WIDTH-1:0]     term_o
);

    logic signed [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
    logic signed [DATA_WIDTH:0]     diff;
    logic signed [2*DATA_WIDTH+1:0] diff_ext;
    logic        [2*DATA_WIDTH+1:0] sq;

    // Operands are extended to the result width so the multiplies are exact.
    assign a_ext    = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
    assign b_ext    = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
    assign prod     = a_ext * b_ext;
    assign diff     = {a_i[DATA_WIDTH-1], a_i} - {b_i[DATA_WIDTH-1], b_i};
    assign diff_ext = {{(DATA_WIDTH+1){diff[DATA_WIDTH]}}, diff};
    assign sq       = diff_ext * diff_ext;

    always_comb begin
        if (op_i == OP_CODE_WIDTH'(OP_SQDIST)) begin
            term_o = ACC_WIDTH'(sq);
        end else begin
            term_o = ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/hsi_vector_engine.sv
// hsi_vector_engine: per-pixel dot product / element-wise product / squared distance.
//   op_code_i, num_bands_i, start_i : configuration and start pulse from the OBI wrapper
//   busy_o, pixel_done_o, error_code_o : status back to the wrapper
//   in1_*/in2_* : FWFT input FIFOs, popped together with in*_rd_o
//   out_data_o, out_wr_o, out_full_i : output FIFO push interface
// Optional: define HSI_ENGINE_TIMEOUT_EN to enable the stall watchdog (TIMEOUT_CYCLES).
module hsi_vector_engine
    import hsi_pkg::*;
#(
    parameter int unsigned OP_CODE_WIDTH   = 4,
    parameter int unsigned NUM_BANDS_WIDTH = 32,
    parameter int unsigned ERR_WIDTH       = 4,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned ACC_WIDTH       = 48,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [OP_CODE_WIDTH-1:0]   op_code_i,
    input  logic [NUM_BANDS_WIDTH-1:0] num_bands_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       pixel_done_o,
    output logic [ERR_WIDTH-1:0]       error_code_o,
    input  logic [DATA_WIDTH-1:0]      in1_data_i,
    input  logic                       in1_empty_i,
    output logic                       in1_rd_o,
    input  logic [DATA_WIDTH-1:0]      in2_data_i,
    input  logic                       in2_empty_i,
    output logic                       in2_rd_o,
    output logic [ACC_WIDTH-1:0]       out_data_o,
    output logic                       out_wr_o,
    input  logic                       out_full_i
);

    hsi_state_e                 state_q, state_d;
    logic [OP_CODE_WIDTH-1:0]   op_q, op_d;
    logic [NUM_BANDS_WIDTH-1:0] nb_q, nb_d;
    logic [NUM_BANDS_WIDTH-1:0] count_q, count_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [ERR_WIDTH-1:0]       err_q, err_d;

    logic [ACC_WIDTH-1:0] term;
    logic is_mul, op_valid, last_band, fire, wr_acc, timeout;

    hsi_mac_unit #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ACC_WIDTH    (ACC_WIDTH),
        .OP_CODE_WIDTH(OP_CODE_WIDTH)
    ) u_mac (
        .a_i   (in1_data_i),
        .b_i   (in2_data_i),
        .op_i  (op_q),
        .term_o(term)
    );

    assign is_mul    = (op_q == OP_CODE_WIDTH'(OP_MUL));
    assign op_valid  = (op_code_i == OP_CODE_WIDTH'(OP_DOT)) ||
                       (op_code_i == OP_CODE_WIDTH'(OP_MUL)) ||
                       (op_code_i == OP_CODE_WIDTH'(OP_SQDIST));
    // num_bands is never 0 in StRun, so the subtraction cannot wrap.
    assign last_band = (count_q == nb_q - NUM_BANDS_WIDTH'(1));
    // OP_MUL writes in the same cycle it pops, so it also needs room downstream.
    assign fire      = (state_q == StRun) && !in1_empty_i && !in2_empty_i &&
                       (!is_mul || !out_full_i);
    assign wr_acc    = (state_q == StWrite) && !out_full_i;

`ifdef HSI_ENGINE_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);
    logic [StallW-1:0] stall_q, stall_d;
    logic              waiting;

    assign waiting = ((state_q == StRun) || (state_q == StWrite)) && !fire && !wr_acc;
    assign timeout = waiting && (stall_q == StallW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        stall_d = '0;
        if (waiting) begin
            stall_d = stall_q + StallW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_q    <= '0;
            nb_q    <= '0;
            count_q <= '0;
            acc_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            nb_q    <= nb_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        nb_d    = nb_q;
        count_d = count_q;
        acc_d   = acc_q;
        err_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (!op_valid) begin
                        err_d = ERR_WIDTH'(ERR_BAD_OP);
                    end else if (num_bands_i == '0) begin
                        err_d = ERR_WIDTH'(ERR_ZERO_BANDS);
                    end else begin
                        state_d = StRun;
                        op_d    = op_code_i;
                        nb_d    = num_bands_i;
                        count_d = '0;
                        acc_d   = '0;
                    end
                end
            end
            StRun: begin
                if (fire) begin
                    count_d = count_q + NUM_BANDS_WIDTH'(1);
                    if (!is_mul) begin
                        acc_d = acc_q + term;
                    end
                    if (last_band) begin
                        state_d = is_mul ? StDone : StWrite;
                    end
                end
            end
            StWrite: begin
                if (wr_acc) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (timeout) begin
            state_d = StIdle;
            err_d   = ERR_WIDTH'(ERR_TIMEOUT);
        end
    end

    // Outputs.
    always_comb begin
        in1_rd_o     = fire;
        in2_rd_o     = fire;
        out_wr_o     = (fire && is_mul) || wr_acc;
        out_data_o   = (state_q == StWrite) ? acc_q : term;
        busy_o       = (state_q != StIdle);
        pixel_done_o = (state_q == StDone);
        error_code_o = err_q;
    end

endmodule

// File: tb/tb_hsi_vector_engine.sv
module tb_hsi_vector_engine;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  op_code_i = '0;
    logic [31:0] num_bands_i = '0;
    logic        start_i = 1'b0;
    logic        busy_o, pixel_done_o;
    logic [3:0]  error_code_o;
    logic [15:0] in1_data_i = '0, in2_data_i = '0;
    logic        in1_empty_i = 1'b1, in2_empty_i = 1'b1;
    logic        in1_rd_o, in2_rd_o;
    logic [47:0] out_data_o;
    logic        out_wr_o;
    logic        out_full_i = 1'b0;

    always #5 clk_i = ~clk_i;

    hsi_vector_engine #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .op_code_i   (op_code_i),
        .num_bands_i (num_bands_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .pixel_done_o(pixel_done_o),
        .error_code_o(error_code_o),
        .in1_data_i  (in1_data_i),
        .in1_empty_i (in1_empty_i),
        .in1_rd_o    (in1_rd_o),
        .in2_data_i  (in2_data_i),
        .in2_empty_i (in2_empty_i),
        .in2_rd_o    (in2_rd_o),
        .out_data_o  (out_data_o),
        .out_wr_o    (out_wr_o),
        .out_full_i  (out_full_i)
    );

    int n_tests = 0, n_fail = 0;

    // FIFO models and observation state
    logic [15:0] q1[$], q2[$], src_a[$], src_b[$];
    logic [47:0] got[$], exp_q[$];
    logic [3:0]  exp_err, err_val;
    bit          stall1, stall2, full_force, rnd, start_req, busy_seen;
    logic [3:0]  start_op;
    logic [31:0] start_nb;
    int cyc, n_pop1, n_pop2, n_done, n_err, n_stray;
    int done_cyc, last_wr_cyc, last_pop_cyc, err_cyc, start_cyc;

    typedef struct {
        logic [3:0]  op;
        int          nb;
        int          a[4];
        int          b[4];
        logic [3:0]  err;
        int          nw;
        logic [47:0] w[3];
    } vec_t;
    vec_t vecs[9];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        got.delete(); exp_q.delete(); src_a.delete(); src_b.delete();
        q1.delete(); q2.delete();
        n_pop1 = 0; n_pop2 = 0; n_done = 0; n_err = 0; n_stray = 0;
        done_cyc = 0; last_wr_cyc = 0; last_pop_cyc = 0; err_cyc = 0;
        err_val = '0; busy_seen = 0;
    endtask

    task automatic push_pair(int a, int b);
        q1.push_back(16'(a)); q2.push_back(16'(b));
        src_a.push_back(16'(a)); src_b.push_back(16'(b));
    endtask

    task automatic request_start(logic [3:0] op, logic [31:0] nb);
        start_req = 1; start_op = op; start_nb = nb;
    endtask

    // One clock: drive at negedge, observe combinational strobes 1 time unit later.
    task automatic cycle();
        @(negedge clk_i);
        start_i     = start_req;
        op_code_i   = start_op;
        num_bands_i = start_nb;
        start_req   = 0;
        in1_empty_i = (q1.size() == 0) || stall1 || (rnd && $urandom_range(0, 3) == 0);
        in2_empty_i = (q2.size() == 0) || stall2 || (rnd && $urandom_range(0, 3) == 0);
        in1_data_i  = (q1.size() != 0) ? q1[0] : 16'h0;
        in2_data_i  = (q2.size() != 0) ? q2[0] : 16'h0;
        out_full_i  = full_force || (rnd && $urandom_range(0, 3) == 0);
        #1;
        cyc++;
        if (start_i) start_cyc = cyc;
        if (busy_o) busy_seen = 1;
        if (in1_rd_o) begin
            if (in1_empty_i) n_stray++; else void'(q1.pop_front());
            n_pop1++; last_pop_cyc = cyc;
        end
        if (in2_rd_o) begin
            if (in2_empty_i) n_stray++; else void'(q2.pop_front());
            n_pop2++;
        end
        if (out_wr_o) begin
            if (out_full_i) n_stray++;
            got.push_back(out_data_o); last_wr_cyc = cyc;
        end
        if (pixel_done_o) begin n_done++; done_cyc = cyc; end
        if (error_code_o != 4'd0) begin n_err++; err_val = error_code_o; err_cyc = cyc; end
    endtask

    task automatic finish_pixel(int budget);
        int k = 0;
        while (n_done == 0 && n_err == 0 && k < budget) begin
            cycle(); k++;
        end
        if (k >= budget) begin
            n_tests++; n_fail++;
            $display("FAIL watchdog: no done/error within %0d cycles, required completion", budget);
        end
        cycle(); cycle();
    endtask

    // Reference model: plain integer arithmetic on the recorded operands.
    task automatic model(logic [3:0] op, logic [31:0] nb);
        longint s = 0, x, y;
        exp_q.delete();
        if (op < 4'd1 || op > 4'd3) exp_err = 4'd1;
        else if (nb == 0) exp_err = 4'd2;
        else exp_err = 4'd0;
        if (exp_err == 4'd0) begin
            for (int i = 0; i < int'(nb); i++) begin
                x = longint'($signed(src_a[i]));
                y = longint'($signed(src_b[i]));
                if (op == 4'd1) s += x * y;
                else if (op == 4'd2) exp_q.push_back(48'(x * y));
                else s += (x - y) * (x - y);
            end
            if (op != 4'd2) exp_q.push_back(48'(s));
        end
    endtask

    task automatic check_pixel(int nb);
        if (exp_err != 4'd0) begin
            check("err_code", err_val, exp_err);
            check("err_pulses", n_err, 1);
            check("err_pops", n_pop1 + n_pop2, 0);
            check("err_busy", busy_seen, 0);
            check("err_done", n_done, 0);
            check("err_writes", got.size(), 0);
        end else begin
            check("done_count", n_done, 1);
            check("no_error", n_err, 0);
            check("pops_in1", n_pop1, nb);
            check("pops_in2", n_pop2, nb);
            check("write_count", got.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++)
                if (i < got.size()) check($sformatf("data[%0d]", i), got[i], exp_q[i]);
            check("done_after_write", done_cyc - last_wr_cyc, 1);
            check("strobe_protocol", n_stray, 0);
            check("idle_after", busy_o, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd1, 4, '{1, 2, 3, 4}, '{5, 6, 7, 8}, 4'd0, 1, '{48'd70, 48'd0, 48'd0}};
        vecs[1] = '{4'd2, 3, '{-2, 3, 32767, 0}, '{4, -5, 32767, 0}, 4'd0, 3,
                    '{48'hFFFF_FFFF_FFF8, 48'hFFFF_FFFF_FFF1, 48'h0000_3FFF_0001}};
        vecs[2] = '{4'd3, 2, '{10, -3, 0, 0}, '{7, 5, 0, 0}, 4'd0, 1, '{48'd73, 48'd0, 48'd0}};
        vecs[3] = '{4'd0, 2, '{1, 2, 0, 0}, '{3, 4, 0, 0}, 4'd1, 0, '{48'd0, 48'd0, 48'd0}};
        vecs[4] = '{4'd5, 2, '{1, 2, 0, 0}, '{3, 4, 0, 0}, 4'd1, 0, '{48'd0, 48'd0, 48'd0}};
        vecs[5] = '{4'd1, 0, '{1, 2, 0, 0}, '{3, 4, 0, 0}, 4'd2, 0, '{48'd0, 48'd0, 48'd0}};
        vecs[6] = '{4'd7, 0, '{1, 2, 0, 0}, '{3, 4, 0, 0}, 4'd1, 0, '{48'd0, 48'd0, 48'd0}};
        vecs[7] = '{4'd1, 2, '{-32768, -32768, 0, 0}, '{-32768, 32767, 0, 0}, 4'd0, 1,
                    '{48'h8000, 48'd0, 48'd0}};
        vecs[8] = '{4'd3, 1, '{-32768, 0, 0, 0}, '{32767, 0, 0, 0}, 4'd0, 1,
                    '{48'hFFFE_0001, 48'd0, 48'd0}};

        stall1 = 0; stall2 = 0; full_force = 0; rnd = 0; start_req = 0;
        start_op = '0; start_nb = '0; cyc = 0; start_cyc = 0;
        clear_obs();

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", pixel_done_o, 0);
        check("rst_err", error_code_o, 0);
        check("rst_rd", in1_rd_o | in2_rd_o, 0);
        check("rst_wr", out_wr_o, 0);
        rst_ni = 1;
        cycle();
        check("idle_busy", busy_o, 0);

        // Directed table
        foreach (vecs[v]) begin
            clear_obs();
            for (int i = 0; i < ((vecs[v].nb > 0) ? vecs[v].nb : 2); i++)
                push_pair(vecs[v].a[i], vecs[v].b[i]);
            exp_err = vecs[v].err;
            for (int i = 0; i < vecs[v].nw; i++) exp_q.push_back(vecs[v].w[i]);
            request_start(vecs[v].op, 32'(vecs[v].nb));
            finish_pixel(100);
            check_pixel(vecs[v].nb);
            if (vecs[v].err == 4'd0)
                check("write_latency", last_wr_cyc - last_pop_cyc,
                      (vecs[v].op == 4'd2) ? 0 : 1);
        end

        // SQDIST with in2 starved mid-run
        clear_obs();
        push_pair(10, 7); push_pair(-3, 5);
        request_start(4'd3, 32'd2);
        cycle(); cycle();
        check("stall_first_pop", n_pop1, 1);
        stall2 = 1;
        repeat (5) cycle();
        check("stall_no_pops", n_pop1 + n_pop2, 2);
        check("stall_busy", busy_o, 1);
        check("stall_no_write", got.size(), 0);
        stall2 = 0;
        finish_pixel(50);
        model(4'd3, 32'd2);
        check_pixel(2);

        // OP_MUL with output full for 3 cycles; a start while busy is ignored
        clear_obs();
        push_pair(1, 2); push_pair(-3, 4); push_pair(5, -6);
        request_start(4'd2, 32'd3);
        cycle(); cycle();
        full_force = 1;
        request_start(4'd1, 32'd1);
        repeat (3) cycle();
        check("full_no_pops", n_pop1, 1);
        check("full_no_writes", got.size(), 1);
        full_force = 0;
        finish_pixel(50);
        model(4'd2, 32'd3);
        check_pixel(3);

        // Reset in the middle of a run
        clear_obs();
        push_pair(2, 3); push_pair(4, 5);
        request_start(4'd1, 32'd4);
        repeat (4) cycle();
        check("pre_reset_busy", busy_o, 1);
        @(negedge clk_i);
        rst_ni = 0;
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_rd", in1_rd_o | out_wr_o, 0);
        repeat (2) cycle();
        rst_ni = 1;
        repeat (3) cycle();
        check("reset_no_done", n_done, 0);
        check("reset_no_err", n_err, 0);
        check("reset_no_write", got.size(), 0);
        check("reset_idle", busy_o, 0);

        // Randomized pixels with random FIFO back-pressure
        for (int t = 0; t < 30; t++) begin
            int r, nb;
            logic [3:0] op;
            clear_obs();
            r  = $urandom_range(0, 11);
            op = (r < 10) ? 4'(1 + r % 3) : ((r == 10) ? 4'd0 : 4'($urandom_range(4, 15)));
            nb = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 6);
            for (int i = 0; i < ((nb > 0) ? nb : 2); i++)
                push_pair(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
            model(op, 32'(nb));
            rnd = 1;
            request_start(op, 32'(nb));
            finish_pixel(400);
            rnd = 0;
            check_pixel(nb);
        end

`ifdef HSI_ENGINE_TIMEOUT_EN
        // Starve in1: watchdog fires, no done, no write
        clear_obs();
        q2.push_back(16'd1); q2.push_back(16'd2);
        request_start(4'd1, 32'd2);
        finish_pixel(60);
        check("timeout_code", err_val, 4'd4);
        check("timeout_no_done", n_done, 0);
        check("timeout_no_write", got.size(), 0);
        check("timeout_delay", (err_cyc - start_cyc >= 16) && (err_cyc - start_cyc <= 18), 1);
        check("timeout_idle", busy_o, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
